// File: rtl/stage12_hazard_ctrl_pkg.sv
// rtl/stage12_hazard_ctrl_pkg.sv - shared types and constants for the IF/ID hazard controller
package stage12_hazard_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when an ID source register is read and matches a nonzero EX load destination.
    function automatic logic src_match(input logic uses, input logic [4:0] src, input logic [4:0] dst);
        return uses && (src == dst) && (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/stage12_hazard_ctrl_if.sv
// rtl/stage12_hazard_ctrl_if.sv - pipeline-side hazard signal bundle
interface stage12_hazard_ctrl_if #(
    parameter int PERF_W = 16
);
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_is_md;
    logic              id_is_mfhilo;
    logic              id_br_taken;
    logic              ex_mem_read;
    logic [4:0]        ex_rt;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              md_start;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md, id_is_mfhilo,
               id_br_taken, ex_mem_read, ex_rt,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md, id_is_mfhilo,
               id_br_taken, ex_mem_read, ex_rt,
        output pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy, stall_cycles
    );
endinterface

// File: rtl/stage12_hazard_ctrl_md_busy_timer.sv
// rtl/stage12_hazard_ctrl_md_busy_timer.sv - mult/div busy window: loadable down-counter plus FSM
module md_busy_timer
    import stage12_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_busy
);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_state <= MD_RUN;
                        r_cnt   <= CNT_W'(MD_LATENCY);
                    end
                end
                MD_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // The 1->0 edge is the last busy cycle, so a follower issued next cycle sees idle.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= MD_IDLE;
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == MD_RUN);

endmodule

// File: rtl/stage12_hazard_ctrl.sv
// rtl/stage12_hazard_ctrl.sv - IF/ID hazard controller: load-use, mult/div and branch-flush sequencing
module stage12_hazard_ctrl
    import stage12_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    stage12_hazard_ctrl_if.slave  bus
);

    logic              w_lu_hz;
    logic              w_md_hz;
    logic              w_stall;
    logic              w_md_busy;
    logic              w_pc_we;
    logic              w_ifid_we;
    logic              w_ifid_flush;
    logic              w_idex_bubble;
    logic              w_md_start;
    logic [PERF_W-1:0] r_stall_cycles;

    assign w_lu_hz = bus.ex_mem_read &&
                     (src_match(bus.id_uses_rs, bus.id_rs, bus.ex_rt) ||
                      src_match(bus.id_uses_rt, bus.id_rt, bus.ex_rt));
    assign w_md_hz = w_md_busy && (bus.id_is_mfhilo || bus.id_is_md);
    assign w_stall = w_lu_hz || w_md_hz;

    // A taken branch is deliberately dropped while stalled; ID holds, so it is seen again next cycle.
    always_comb begin
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_md_start    = 1'b0;
        if (!reset) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (w_stall) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_bubble = 1'b1;
        end else begin
            w_ifid_flush = bus.id_br_taken;
            w_md_start   = bus.id_is_md;
        end
    end

    md_busy_timer #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_busy_timer (
        .clk     (clk),
        .rst_n   (reset),
        .i_start (w_md_start),
        .o_busy  (w_md_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign bus.pc_we        = w_pc_we;
    assign bus.ifid_we      = w_ifid_we;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_bubble  = w_idex_bubble;
    assign bus.md_start     = w_md_start;
    assign bus.md_busy      = w_md_busy;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_stage12_hazard_ctrl.sv
// tb/tb_stage12_hazard_ctrl.sv - directed self-checking bench for stage12_hazard_ctrl
module tb_stage12_hazard_ctrl;

    localparam int PERF_W = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    stage12_hazard_ctrl_if #(.PERF_W(PERF_W)) bus ();

    stage12_hazard_ctrl #(
        .MD_LATENCY (4),
        .CNT_W      (3),
        .PERF_W     (PERF_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rs   = 1'b0;
        bus.id_uses_rt   = 1'b0;
        bus.id_is_md     = 1'b0;
        bus.id_is_mfhilo = 1'b0;
        bus.id_br_taken  = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_rt        = 5'd0;
    endtask

    task automatic chk_ctl(input string tag, input logic pc, input logic ifid, input logic fl, input logic bub);
        chk({tag, ".pc_we"},       16'(bus.pc_we),       16'(pc));
        chk({tag, ".ifid_we"},     16'(bus.ifid_we),     16'(ifid));
        chk({tag, ".ifid_flush"},  16'(bus.ifid_flush),  16'(fl));
        chk({tag, ".idex_bubble"}, 16'(bus.idex_bubble), 16'(bub));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr();
        reset = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.id_rs        = 5'($urandom);
            bus.id_rt        = 5'($urandom);
            bus.id_uses_rs   = 1'($urandom);
            bus.id_uses_rt   = 1'($urandom);
            bus.id_is_md     = 1'b1;
            bus.id_is_mfhilo = 1'($urandom);
            bus.id_br_taken  = 1'($urandom);
            bus.ex_mem_read  = 1'($urandom);
            bus.ex_rt        = 5'($urandom);
            #1;
            chk_ctl("rst", 1'b0, 1'b0, 1'b1, 1'b1);
            chk("rst.md_start", 16'(bus.md_start), 16'd0);
            chk("rst.md_busy", 16'(bus.md_busy), 16'd0);
            chk("rst.stall_cycles", 16'(bus.stall_cycles), 16'd0);
            tick();
        end
        clr();
        reset = 1'b1;
        #1;
        chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Load-use on rs: one stalled cycle, then normal flow
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b1;
        #1;
        chk_ctl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        bus.ex_mem_read = 1'b0;
        #1;
        chk_ctl("lu_rs_after", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_rs.stall_cycles", 16'(bus.stall_cycles), 16'd1);

        // Load-use on rt, and rt match without use
        clr();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b0;
        #1;
        chk_ctl("rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);
        bus.id_uses_rt = 1'b1;
        #1;
        chk_ctl("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        clr();
        #1;
        chk("lu_rt.stall_cycles", 16'(bus.stall_cycles), 16'd2);

        // $zero destination never stalls
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
        #1;
        chk_ctl("zero", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        clr();

        // Branch alone, then branch with load-use
        bus.id_br_taken = 1'b1;
        #1;
        chk_ctl("br", 1'b1, 1'b1, 1'b1, 1'b0);
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4; bus.id_rt = 5'd4; bus.id_uses_rt = 1'b1;
        #1;
        chk_ctl("br_lu", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        bus.ex_mem_read = 1'b0;
        #1;
        chk_ctl("br_after", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("br.stall_cycles", 16'(bus.stall_cycles), 16'd3);
        tick();
        clr();

        // Clear the perf counter before the MD sequence
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("md0.stall_cycles", 16'(bus.stall_cycles), 16'd0);

        // MD issue, one independent instruction, then mfhi
        bus.id_is_md = 1'b1;
        #1;
        chk("md.start", 16'(bus.md_start), 16'd1);
        chk("md.busy_pre", 16'(bus.md_busy), 16'd0);
        tick();
        clr();
        #1;
        chk("md.start_once", 16'(bus.md_start), 16'd0);
        chk("md.busy1", 16'(bus.md_busy), 16'd1);
        chk_ctl("md.indep", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        bus.id_is_mfhilo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mfhi.busy", 16'(bus.md_busy), 16'd1);
            chk_ctl("mfhi.stall", 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        #1;
        chk("mfhi.busy_done", 16'(bus.md_busy), 16'd0);
        chk_ctl("mfhi.issue", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mfhi.stall_cycles", 16'(bus.stall_cycles), 16'd3);
        tick();

        // Second mult while busy stalls and does not restart the unit
        clr();
        bus.id_is_md = 1'b1;
        #1;
        chk("md2.start", 16'(bus.md_start), 16'd1);
        tick();
        #1;
        chk("md2.blocked_start", 16'(bus.md_start), 16'd0);
        chk_ctl("md2.stall", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        clr();
        #1;
        chk("md2.stall_cycles", 16'(bus.stall_cycles), 16'd4);
        chk("md2.busy_cnt3", 16'(bus.md_busy), 16'd1);
        tick();
        chk("md2.busy_cnt2", 16'(bus.md_busy), 16'd1);

        // Asynchronous reset at count 2
        reset = 1'b0;
        #1;
        chk("arst.md_busy", 16'(bus.md_busy), 16'd0);
        chk("arst.stall_cycles", 16'(bus.stall_cycles), 16'd0);
        chk_ctl("arst", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        chk("arst.md_busy_after", 16'(bus.md_busy), 16'd0);

        // Saturation over 20 stalled cycles
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd3; bus.id_rs = 5'd3; bus.id_uses_rs = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat.14", 16'(bus.stall_cycles), 16'd14);
            if (i == 15) chk("sat.15", 16'(bus.stall_cycles), 16'd15);
        end
        chk("sat.20", 16'(bus.stall_cycles), 16'd15);
        clr();
        #1;
        chk_ctl("sat.release", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sat.hold", 16'(bus.stall_cycles), 16'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
